// File: rtl/tile_pkg.sv
// Shared types and lane helpers for the Piano Tiles playfield generator.
package tile_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } game_state_e;

  typedef logic [1:0] lane_t;

  function automatic logic [NUM_LANES-1:0] lane_to_onehot(input lane_t lane);
    return NUM_LANES'(1) << lane;
  endfunction

  // Avoid repeating the previous lane so consecutive tiles never stack.
  function automatic lane_t pick_lane(input lane_t cand, input lane_t prev);
    return (cand == prev) ? lane_t'(cand + 2'd1) : cand;
  endfunction

  function automatic lane_t onehot_to_lane(input logic [NUM_LANES-1:0] onehot);
    lane_t lane;
    lane = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (onehot[i]) lane = lane_t'(i);
    end
    return lane;
  endfunction

endpackage

// File: rtl/tile_row_gen_if.sv
// Game-control and playfield bus between the key decoder/renderer and tile_row_gen.
interface tile_row_gen_if #(
  parameter int ROWS    = 8,
  parameter int SCORE_W = 10
);
  logic [4:0]          rnd_in;
  logic                start;
  logic                scroll_tick;
  logic                key_valid;
  logic [1:0]          key_lane;
  logic [4*ROWS-1:0]   rows_out;
  logic [SCORE_W-1:0]  score;
  logic [1:0]          state;
  logic                hit_pulse;
  logic                miss_pulse;

  modport master (
    output rnd_in, start, scroll_tick, key_valid, key_lane,
    input  rows_out, score, state, hit_pulse, miss_pulse
  );

  modport slave (
    input  rnd_in, start, scroll_tick, key_valid, key_lane,
    output rows_out, score, state, hit_pulse, miss_pulse
  );
endinterface

// File: rtl/tile_hit_judge.sv
// Combinational priority search for the lowest occupied, not-yet-hit row.
module tile_hit_judge
  import tile_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int IDX_W = $clog2(ROWS)
) (
  input  logic [ROWS-1:0][NUM_LANES-1:0] lanes,
  input  logic [ROWS-1:0]                hits,
  output logic [IDX_W-1:0]               tgt_idx,
  output logic                           tgt_valid,
  output lane_t                          tgt_lane
);

  // NOTE: every output gets a default before the search; a missing default
  // on any path would infer a latch.
  always_comb begin
    tgt_valid = 1'b0;
    tgt_idx   = '0;
    tgt_lane  = '0;
    // Walk downward so the last match written is the lowest index.
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (lanes[i] != '0 && !hits[i]) begin
        tgt_valid = 1'b1;
        tgt_idx   = IDX_W'(i);
        tgt_lane  = onehot_to_lane(lanes[i]);
      end
    end
  end

endmodule

// File: rtl/tile_row_gen.sv
// Scrolling playfield, key judging, score and IDLE/RUN/OVER game state.
module tile_row_gen
  import tile_pkg::*;
#(
  parameter int ROWS    = 8,
  parameter int SCORE_W = 10
) (
  input logic              clk,
  input logic              rst,
  tile_row_gen_if.slave    bus
);

  localparam int IDX_W = $clog2(ROWS);

  game_state_e                     state_q, state_d;
  logic [ROWS-1:0][NUM_LANES-1:0]  lanes_q, lanes_d;
  logic [ROWS-1:0]                 hits_q, hits_d;
  logic [SCORE_W-1:0]              score_q, score_d;
  lane_t                           prev_q, prev_d;
  logic                            hit_q, hit_d;
  logic                            miss_q, miss_d;

  logic [IDX_W-1:0]                tgt_idx;
  logic                            tgt_valid;
  lane_t                           tgt_lane;
  logic [ROWS-1:0]                 hits_k;
  logic                            ended;
  lane_t                           spawn_lane;
  logic                            unused_rnd;

  // Only the low two bits pick a lane; the rest of the LFSR word is unused.
  assign unused_rnd = ^bus.rnd_in[4:2];
  assign spawn_lane = pick_lane(lane_t'(bus.rnd_in[1:0]), prev_q);

  tile_hit_judge #(.ROWS(ROWS), .IDX_W(IDX_W)) u_judge (
    .lanes     (lanes_q),
    .hits      (hits_q),
    .tgt_idx   (tgt_idx),
    .tgt_valid (tgt_valid),
    .tgt_lane  (tgt_lane)
  );

  always_comb begin
    state_d = state_q;
    lanes_d = lanes_q;
    hits_d  = hits_q;
    score_d = score_q;
    prev_d  = prev_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    hits_k  = hits_q;
    ended   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          state_d = ST_RUN;
          lanes_d = '0;
          hits_d  = '0;
          score_d = '0;
          prev_d  = '0;
        end
      end
      ST_RUN: begin
        if (bus.start) begin
          lanes_d = '0;
          hits_d  = '0;
          score_d = '0;
          prev_d  = '0;
        end else begin
          // Key judging sees the pre-shift rows; scrolling sees the post-key hits.
          if (bus.key_valid && tgt_valid) begin
            if (bus.key_lane == tgt_lane) begin
              hits_k[tgt_idx] = 1'b1;
              hit_d           = 1'b1;
              if (score_q != '1) score_d = score_q + 1'b1;
            end else begin
              ended = 1'b1;
            end
          end
          hits_d = hits_k;

          if (!ended && bus.scroll_tick) begin
            if (lanes_q[0] != '0 && !hits_k[0]) begin
              ended = 1'b1;
            end else begin
              for (int i = 0; i < ROWS - 1; i++) begin
                lanes_d[i] = lanes_q[i+1];
                hits_d[i]  = hits_k[i+1];
              end
              lanes_d[ROWS-1] = lane_to_onehot(spawn_lane);
              hits_d[ROWS-1]  = 1'b0;
              prev_d          = spawn_lane;
            end
          end

          if (ended) begin
            state_d = ST_OVER;
            miss_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the row array is a handful of flops, not a RAM, so it is reset
  // along with everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lanes_q <= '0;
      hits_q  <= '0;
      score_q <= '0;
      prev_q  <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lanes_q <= lanes_d;
      hits_q  <= hits_d;
      score_q <= score_d;
      prev_q  <= prev_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      bus.rows_out[4*i +: 4] = hits_q[i] ? 4'b0000 : lanes_q[i];
    end
  end

  assign bus.score      = score_q;
  assign bus.state      = state_q;
  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;

endmodule

// File: tb/tb_tile_row_gen.sv
// Directed self-checking bench for tile_row_gen with hand-computed playfields.
module tb_tile_row_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  tile_row_gen_if #(.ROWS(8), .SCORE_W(10)) bus ();

  tile_row_gen #(.ROWS(8), .SCORE_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic s, input logic t, input logic kv,
                     input logic [1:0] kl, input logic [4:0] r);
    bus.start       = s;
    bus.scroll_tick = t;
    bus.key_valid   = kv;
    bus.key_lane    = kl;
    bus.rnd_in      = r;
    @(posedge clk);
    #1;
    bus.start       = 1'b0;
    bus.scroll_tick = 1'b0;
    bus.key_valid   = 1'b0;
    bus.key_lane    = 2'd0;
    bus.rnd_in      = 5'd0;
  endtask

  task automatic tick(input logic [4:0] r);
    cyc(1'b0, 1'b1, 1'b0, 2'd0, r);
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [31:0] rows,
                           input logic [9:0] sc, input logic hp, input logic mp);
    check({tag, ".state"}, 64'(bus.state), 64'(st));
    check({tag, ".rows"},  64'(bus.rows_out), 64'(rows));
    check({tag, ".score"}, 64'(bus.score), 64'(sc));
    check({tag, ".hit"},   64'(bus.hit_pulse), 64'(hp));
    check({tag, ".miss"},  64'(bus.miss_pulse), 64'(mp));
  endtask

  logic [4:0] fill_rnd [8] = '{5'h1f, 5'h03, 5'h02, 5'h02, 5'h01, 5'h00, 5'h00, 5'h06};

  initial begin
    bus.start = 1'b0; bus.scroll_tick = 1'b0; bus.key_valid = 1'b0;
    bus.key_lane = 2'd0; bus.rnd_in = 5'd0;

    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 5'd0);
    rst = 1'b0;
    check_all("reset", 2'b00, 32'h0, 10'd0, 1'b0, 1'b0);

    tick(5'h1f);
    cyc(1'b0, 1'b0, 1'b1, 2'd1, 5'd0);
    check_all("idle_ignore", 2'b00, 32'h0, 10'd0, 1'b0, 1'b0);

    cyc(1'b1, 1'b0, 1'b0, 2'd0, 5'd0);
    check_all("start", 2'b01, 32'h0, 10'd0, 1'b0, 1'b0);

    cyc(1'b0, 1'b0, 1'b1, 2'd2, 5'd0);
    check_all("key_no_target", 2'b01, 32'h0, 10'd0, 1'b0, 1'b0);

    tick(fill_rnd[0]);
    check_all("spawn1", 2'b01, 32'h8000_0000, 10'd0, 1'b0, 1'b0);
    tick(fill_rnd[1]);
    check_all("spawn_repeat", 2'b01, 32'h1800_0000, 10'd0, 1'b0, 1'b0);
    for (int i = 2; i < 8; i++) tick(fill_rnd[i]);
    check_all("fill8", 2'b01, 32'h4212_8418, 10'd0, 1'b0, 1'b0);

    cyc(1'b0, 1'b0, 1'b1, 2'd3, 5'd0);
    check_all("hit_row0", 2'b01, 32'h4212_8410, 10'd1, 1'b1, 1'b0);

    tick(5'h00);
    check_all("shift_after_hit", 2'b01, 32'h1421_2841, 10'd1, 1'b0, 1'b0);

    cyc(1'b0, 1'b1, 1'b1, 2'd0, 5'h01);
    check_all("hit_and_tick", 2'b01, 32'h2142_1284, 10'd2, 1'b1, 1'b0);

    cyc(1'b0, 1'b1, 1'b1, 2'd1, 5'h02);
    check_all("wrong_key", 2'b10, 32'h2142_1284, 10'd2, 1'b0, 1'b1);

    cyc(1'b0, 1'b1, 1'b1, 2'd2, 5'h03);
    check_all("over_hold", 2'b10, 32'h2142_1284, 10'd2, 1'b0, 1'b0);

    cyc(1'b1, 1'b0, 1'b0, 2'd0, 5'd0);
    check_all("restart_over", 2'b01, 32'h0, 10'd0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) tick(5'h00);
    check_all("fill_alt", 2'b01, 32'h1212_1212, 10'd0, 1'b0, 1'b0);

    tick(5'h00);
    check_all("miss_row0", 2'b10, 32'h1212_1212, 10'd0, 1'b0, 1'b1);

    cyc(1'b0, 1'b1, 1'b1, 2'd1, 5'h00);
    check_all("miss_hold", 2'b10, 32'h1212_1212, 10'd0, 1'b0, 1'b0);

    cyc(1'b1, 1'b0, 1'b0, 2'd0, 5'd0);
    tick(5'h00);
    check_all("rerun_spawn", 2'b01, 32'h2000_0000, 10'd0, 1'b0, 1'b0);

    cyc(1'b1, 1'b1, 1'b1, 2'd1, 5'h00);
    check_all("restart_run", 2'b01, 32'h0, 10'd0, 1'b0, 1'b0);

    // prev_lane must be back at 0, so cand 0 spawns lane 1 again.
    tick(5'h00);
    check_all("prev_cleared", 2'b01, 32'h2000_0000, 10'd0, 1'b0, 1'b0);

    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 2'd0, 5'h1f);
    rst = 1'b0;
    check_all("reset_run", 2'b00, 32'h0, 10'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_row_gen.md
Name: tile_row_gen

Overview:
Consumes the 5-bit pseudo-random word from the LFSR counter and maintains the scrolling Piano Tiles playfield.
- On each scroll tick it shifts the rows down and spawns one tile in a random lane at the top row.
- It judges player key presses against the lowest pending tile.
- It keeps the score and runs the IDLE/RUN/OVER game state.
- The playfield is read by the display renderer; the key decoder feeds it.

Parameters:
ROWS, 8, number of playfield rows (row 0 = bottom/hit row, row ROWS-1 = spawn row); legal 2..16
SCORE_W, 10, score counter width

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rnd_in  input  5  LFSR output word, sampled only on spawn cycles
start  input  1  one-cycle pulse: begin or restart a game
scroll_tick  input  1  one-cycle pulse: advance playfield one row
key_valid  input  1  one-cycle pulse: player pressed a lane key
key_lane  input  2  lane of the key press (0..3)
rows_out  output  4*ROWS  pending tiles; rows_out[4*i +: 4] = one-hot lane of row i, 0 if empty or already hit
score  output  SCORE_W  tiles hit this game, saturating
state  output  2  00 IDLE, 01 RUN, 10 OVER
hit_pulse  output  1  one cycle, correct key accepted
miss_pulse  output  1  one cycle, game ended (missed tile or wrong key)

Behaviour:
- Reset (rst high at a clk edge), all outputs registered:
  - state=IDLE; all rows empty with hit flags cleared; score=0; pulses=0; prev_lane=0.
  - Reset overrides every other input in that cycle.
- Storage: per row, a 4-bit one-hot lane (0 = empty) plus a hit flag. rows_out = lane masked by !hit.
- IDLE:
  - start -> clear rows, score=0, prev_lane=0, go RUN next cycle.
  - scroll_tick and key_valid are ignored.
- RUN, key judging (evaluated first, against pre-shift contents):
  - Target = lowest-index row that is occupied and not hit.
  - key_valid with a target and key_lane == target lane -> set target's hit flag; score+1 (hold at all-ones); hit_pulse=1.
  - key_valid with a target and a lane mismatch -> state=OVER; miss_pulse=1; no shift this cycle even if scroll_tick.
  - key_valid with no target -> ignored (no pulse).
- RUN, scroll_tick (applied after key judging, on the post-key state):
  - If row 0 is occupied and not hit -> state=OVER, miss_pulse=1, no shift; rows freeze showing the missed tile.
  - Otherwise: row[i] <= row[i+1] for i < ROWS-1, with hit flags moving together with their rows.
  - Spawn row: cand = rnd_in[1:0]. lane = cand if cand != prev_lane, else (cand+1) mod 4. Spawn row = one-hot(lane), hit=0; prev_lane <= lane.
  - A same-cycle hit on row 0 plus scroll_tick is a valid hit: no miss; the row shifts out.
- Latency: all effects are visible on outputs the cycle after the triggering input edge.
- OVER:
  - Rows, score and prev_lane hold; scroll_tick and key_valid are ignored.
  - start -> same clear as IDLE, go RUN.
- start while in RUN -> restart: clear, score=0, stay RUN. start takes priority over key_valid and scroll_tick in the same cycle.
- Pulses are never both high in the same cycle.
- rnd_in is combinationally unconstrained; it is sampled only on spawn cycles.

Decomposition:
- Package tile_pkg:
  - state enum (IDLE/RUN/OVER) and the 2-bit lane typedef.
  - NUM_LANES=4.
  - Function lane_to_onehot.
  - Function pick_lane(cand, prev).
- One natural sub-module: tile_hit_judge. It is combinational: it takes the row array and hit flags and returns target index, target valid and target lane. It keeps the priority search out of the state/shift logic.

Test Plan:
- Reset, start, scroll_tick with rnd_in=5'h1f -> row 7 = 4'b1000, prev_lane=3, state=01, score=0.
- Next tick with rnd_in=5'h03 (cand 3 == prev) -> row 7 = 4'b0001, row 6 = 4'b1000.
- First tile reaches row 0 after 8 ticks. Then key_valid, key_lane=3 -> hit_pulse, score=1, rows_out[3:0]=0. Next tick -> no miss, shift continues.
- Leave a tile unhit in row 0, then scroll_tick -> miss_pulse, state=10, rows_out frozen. Further ticks and keys cause no change.
- With target lane 2, press key_lane=1 in the same cycle as scroll_tick -> state=OVER, miss_pulse, no shift, score unchanged.
- In OVER with score=5, pulse start -> state=RUN, score=0, rows_out=0. Assert rst mid-RUN -> state=IDLE, all outputs 0 the next cycle.
